// File: rtl/mix_chain_sequencer_if.sv
// mix_chain_sequencer_if: host configuration, run control and valve-driver
// signals of the mixing-chain sequencer, bundled into one port.
// master = host side, slave = sequencer side.
interface mix_chain_sequencer_if #(
    parameter int N_INLETS = 3,
    parameter int CNT_W    = 16,
    parameter int IDX_W    = (N_INLETS > 1) ? $clog2(N_INLETS) : 1
);
    logic                cfg_we;
    logic [IDX_W-1:0]    cfg_idx;
    logic [CNT_W-1:0]    cfg_dwell;
    logic [CNT_W-1:0]    cfg_flush;
    logic                start;
    logic [N_INLETS-1:0] inlet_mask;
    logic                abort;
    logic [N_INLETS-1:0] valve_in;
    logic                valve_out;
    logic [IDX_W-1:0]    cur_inlet;
    logic                busy;
    logic                done;
    logic                aborted;

    modport master (
        output cfg_we, cfg_idx, cfg_dwell, cfg_flush, start, inlet_mask, abort,
        input  valve_in, valve_out, cur_inlet, busy, done, aborted
    );

    modport slave (
        input  cfg_we, cfg_idx, cfg_dwell, cfg_flush, start, inlet_mask, abort,
        output valve_in, valve_out, cur_inlet, busy, done, aborted
    );
endinterface

// File: rtl/mix_chain_sequencer.sv
// mix_chain_sequencer: opens the enabled inlet valves of a serial mixing
// chain one at a time in ascending order, each for its programmed dwell,
// with an all-closed settle interval after every inlet.
// Define MIXSEQ_FLUSH_EN to compile in the outlet flush phase and its
// flush-length register; without it valve_out is tied low.
module mix_chain_sequencer #(
    parameter int N_INLETS      = 3,
    parameter int CNT_W         = 16,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    mix_chain_sequencer_if.slave bus
);
    localparam int IDX_W = (N_INLETS > 1) ? $clog2(N_INLETS) : 1;
    localparam int SET_W = $clog2(SETTLE_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE,
        OPEN,
        SETTLE,
`ifdef MIXSEQ_FLUSH_EN
        FLUSH,
`endif
        FIN
    } state_t;

    state_t              state;
    logic [CNT_W-1:0]    dwell [N_INLETS];
    logic [N_INLETS-1:0] run_mask;
    logic [N_INLETS-1:0] valve_in_r;
    logic [CNT_W-1:0]    cnt;
    logic [SET_W-1:0]    settle_cnt;
    logic [IDX_W-1:0]    cur;
    logic                busy_r;
    logic                done_r;
    logic                aborted_r;

`ifdef MIXSEQ_FLUSH_EN
    logic [CNT_W-1:0]    flush_len;
    logic                valve_out_r;
    logic                flush_go;
`endif

    logic [N_INLETS-1:0] scan_mask;
    logic                sel_found;
    logic [IDX_W-1:0]    sel_idx;
    logic [CNT_W-1:0]    sel_dwell;
    logic [N_INLETS-1:0] sel_onehot;
    logic                abort_run;
    logic                advance;
    logic                cfg_ok;

    // Pick the lowest qualifying inlet: from the live mask when starting,
    // otherwise from the captured mask strictly above the inlet just served.
    always_comb begin
        scan_mask  = (state == IDLE) ? bus.inlet_mask : run_mask;
        sel_found  = 1'b0;
        sel_idx    = '0;
        sel_dwell  = '0;
        sel_onehot = '0;
        for (int i = N_INLETS - 1; i >= 0; i--) begin
            if (scan_mask[i] && (dwell[i] != '0) &&
                ((state == IDLE) || (IDX_W'(i) > cur))) begin
                sel_found     = 1'b1;
                sel_idx       = IDX_W'(i);
                sel_dwell     = dwell[i];
                sel_onehot    = '0;
                sel_onehot[i] = 1'b1;
            end
        end
    end

    // Abort only matters during a run; advancing covers both the start of a
    // run and the end of each settle interval.
    assign abort_run = bus.abort && busy_r;
    assign advance   = ((state == IDLE) && bus.start && !bus.abort) ||
                       ((state == SETTLE) && !bus.abort && (settle_cnt == SET_W'(1)));
    assign cfg_ok    = bus.cfg_we && !busy_r && (int'(bus.cfg_idx) < N_INLETS);

`ifdef MIXSEQ_FLUSH_EN
    assign flush_go  = (flush_len != '0);
`endif

    // Configuration registers; frozen while a run is in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_INLETS; i++) dwell[i] <= '0;
`ifdef MIXSEQ_FLUSH_EN
            flush_len <= '0;
`endif
        end else if (cfg_ok) begin
            for (int i = 0; i < N_INLETS; i++) begin
                if (bus.cfg_idx == IDX_W'(i)) dwell[i] <= bus.cfg_dwell;
            end
`ifdef MIXSEQ_FLUSH_EN
            flush_len <= bus.cfg_flush;
`endif
        end
    end

    // Sequencer FSM with registered valve and status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            run_mask    <= '0;
            valve_in_r  <= '0;
            cnt         <= '0;
            settle_cnt  <= '0;
            cur         <= '0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            aborted_r   <= 1'b0;
`ifdef MIXSEQ_FLUSH_EN
            valve_out_r <= 1'b0;
`endif
        end else begin
            done_r    <= 1'b0;
            aborted_r <= 1'b0;
            if (abort_run) begin
                state       <= IDLE;
                valve_in_r  <= '0;
                cnt         <= '0;
                settle_cnt  <= '0;
                busy_r      <= 1'b0;
                aborted_r   <= 1'b1;
`ifdef MIXSEQ_FLUSH_EN
                valve_out_r <= 1'b0;
`endif
            end else if (advance) begin
                if (state == IDLE) run_mask <= bus.inlet_mask;
                settle_cnt <= '0;
                if (sel_found) begin
                    state      <= OPEN;
                    valve_in_r <= sel_onehot;
                    cur        <= sel_idx;
                    cnt        <= sel_dwell;
                    busy_r     <= 1'b1;
                end
`ifdef MIXSEQ_FLUSH_EN
                else if (flush_go) begin
                    state       <= FLUSH;
                    valve_out_r <= 1'b1;
                    cnt         <= flush_len;
                    busy_r      <= 1'b1;
                end
`endif
                else begin
                    state  <= FIN;
                    busy_r <= 1'b0;
                    done_r <= 1'b1;
                end
            end else begin
                case (state)
                    OPEN: begin
                        if (cnt == CNT_W'(1)) begin
                            state      <= SETTLE;
                            valve_in_r <= '0;
                            cnt        <= '0;
                            settle_cnt <= SET_W'(SETTLE_CYCLES);
                        end else begin
                            cnt <= cnt - CNT_W'(1);
                        end
                    end
                    SETTLE: settle_cnt <= settle_cnt - SET_W'(1);
`ifdef MIXSEQ_FLUSH_EN
                    FLUSH: begin
                        if (cnt == CNT_W'(1)) begin
                            state       <= FIN;
                            valve_out_r <= 1'b0;
                            cnt         <= '0;
                            busy_r      <= 1'b0;
                            done_r      <= 1'b1;
                        end else begin
                            cnt <= cnt - CNT_W'(1);
                        end
                    end
`endif
                    FIN:     state <= IDLE;
                    default: state <= state;
                endcase
            end
        end
    end

    assign bus.valve_in  = valve_in_r;
    assign bus.cur_inlet = cur;
    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.aborted   = aborted_r;

`ifdef MIXSEQ_FLUSH_EN
    assign bus.valve_out = valve_out_r;
`else
    logic unused_flush;
    assign unused_flush  = ^bus.cfg_flush;
    assign bus.valve_out = 1'b0;
`endif
endmodule

// File: doc/mix_chain_sequencer.md
# mix_chain_sequencer

Parametrised valve-actuation sequencer for a serial mixing chain: N reagent inlets feed a serpentine/diffusion-mixer network, and one outlet flush valve drains it. On a start request the block opens the enabled inlet valves one at a time. Each inlet stays open for its programmed dwell, then all valves close for a fixed settle interval. An optional flush of the outlet follows. It sits between the host configuration bus and the pneumatic valve drivers of the chip, and replaces hand-timed valve scripts for chains such as the three-inlet toilet assay.

## Interface
- N_INLETS, 3, number of inlet valves (1..16)
- CNT_W, 16, width of dwell/flush counters
- SETTLE_CYCLES, 4, all-valves-closed cycles after each inlet (>=1)
- IDX_W, max(1,$clog2(N_INLETS)), derived; not overridden
- clk  input  1  sole clock; all state on rising edge
- rst_n  input  1  asynchronous, active-low reset
- cfg_we  input  1  write cfg_dwell into dwell register cfg_idx and cfg_flush into flush register
- cfg_idx  input  IDX_W  inlet index for dwell write
- cfg_dwell  input  CNT_W  dwell cycles for inlet cfg_idx
- cfg_flush  input  CNT_W  flush cycles
- start  input  1  run request, sampled only in IDLE
- inlet_mask  input  N_INLETS  inlets enabled for this run, captured with start
- abort  input  1  terminate run immediately
- valve_in  output  N_INLETS  inlet valve opens, at most one bit high
- valve_out  output  1  outlet flush valve
- cur_inlet  output  IDX_W  index of inlet currently open or last opened
- busy  output  1  run in progress
- done  output  1  one-cycle pulse, run completed normally
- aborted  output  1  one-cycle pulse, run terminated by abort

## Operation
- States: IDLE, OPEN, SETTLE, FLUSH, FIN.
- IDLE: start=1 and abort=0. Capture inlet_mask into run_mask and select the lowest set bit.
  - Target is OPEN if the selected inlet's dwell is non-zero. Otherwise scan further; zero-dwell inlets are skipped.
  - If no inlet qualifies, target is FLUSH, or FIN if flush=0.
- OPEN: valve_in[cur] high for exactly dwell[cur] cycles, then SETTLE.
- SETTLE: all valves closed for SETTLE_CYCLES cycles. Then go to the next qualifying inlet above cur in OPEN, else FLUSH (flush≠0) or FIN.
- FLUSH: valve_out high for flush cycles, then FIN.
- FIN: done=1 for one cycle, then IDLE.
- Inlets are served in ascending index order and each at most once per run.
- abort while busy: next cycle all valves closed, aborted=1, state IDLE; counters cleared. Abort has priority over every other transition. Abort in IDLE is a no-op and drops a coincident start.
- cfg_we while busy is ignored; dwell/flush are stable for the whole run. cfg_idx >= N_INLETS is ignored.
- start while busy is ignored (no queuing).
- Invariant: popcount(valve_in)+valve_out <= 1 every cycle. Any two valve openings are separated by >= 1 closed cycle (break-before-make).
- Reset values: all outputs 0, state IDLE, all dwell registers 0, flush register 0.

## Timing
- start sampled at edge T0 gives busy=1 and the first valve open from cycle T0+1. No dead cycle before the first valve.
- An open inlet with dwell D occupies cycles [t, t+D-1]. Settle occupies [t+D, t+D+SETTLE_CYCLES-1].
- done is asserted in the cycle after the last flush cycle, or after the last settle cycle if flush is skipped. busy falls in the same cycle as done.
- Run length = 1 + Σ(D_i + SETTLE_CYCLES) over served inlets + F cycles of busy-then-done.
- abort at edge Ta gives valves 0, busy 0 and aborted 1 in cycle Ta+1.
- rst_n asserted mid-run closes all valves asynchronously and immediately. No done or aborted pulse is emitted.
- Dwell D = 2^CNT_W−1 must hold exactly without counter wrap.

## Configuration
- MIXSEQ_FLUSH_EN defined: FLUSH state and valve_out behave as above.
- MIXSEQ_FLUSH_EN undefined:
  - FLUSH state and flush register are removed.
  - valve_out is tied 0 and cfg_flush is ignored; ports are retained.
  - The last SETTLE goes directly to FIN.

## Test plan
- N_INLETS=3, dwell={5,3,7}, flush=4, SETTLE=4, mask=3'b111, start at T0.
  - valve_in=001 cycles 1–5, 010 cycles 10–12, 100 cycles 17–23, valve_out cycles 28–31, done at 32.
- mask=3'b101, dwell[0]=0, dwell[2]=2, flush=0: inlet 0 skipped, valve_in=100 cycles 1–2, done at 7. Not compiled with MIXSEQ_FLUSH_EN: identical.
- abort at cycle 3 of the first run: valves all 0 and aborted=1 at cycle 4, done never asserted. Next start runs normally from inlet 0.
- cfg_we writing dwell[1]=9 while busy: no effect on the current run or the next run. A write after done takes effect.
- start and abort together in IDLE: busy stays 0 and no pulses. start while busy: ignored, and the run length is unchanged.
- Every scenario: assertion that at most one valve is open and a closed gap exists between consecutive openings. rst_n low mid-OPEN gives all outputs 0 immediately.
